// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS control-word pipeline: field layout,
// forwarding select encodings, per-stage register formats and the
// forwarding compare used by the forwarding unit.
package mips_ctrl_pkg;

    localparam int unsigned CW_W  = 9;
    localparam int unsigned REG_W = 5;

    // Control word bit positions
    localparam int unsigned CW_MEMTOREG = 8;
    localparam int unsigned CW_REGWRITE = 7;
    localparam int unsigned CW_BRANCH   = 6;
    localparam int unsigned CW_MEMREAD  = 5;
    localparam int unsigned CW_MEMWRITE = 4;
    localparam int unsigned CW_REGDST   = 3;
    localparam int unsigned CW_ALUSRC   = 2;
    localparam int unsigned CW_RTYPE    = 1;
    localparam int unsigned CW_BEQ      = 0;

    // Field slices: WB, M and EX groups
    localparam int unsigned WB_HI = 8;
    localparam int unsigned WB_LO = 7;
    localparam int unsigned M_HI  = 6;
    localparam int unsigned M_LO  = 4;
    localparam int unsigned EX_HI = 3;
    localparam int unsigned EX_LO = 0;

    // ALU operand source select
    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    // ID/EX carries the full word plus all three register specifiers
    typedef struct packed {
        logic [CW_W-1:0]  cw;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
    } idex_t;

    // EX/MEM keeps only the WB and M groups plus the resolved destination
    typedef struct packed {
        logic [CW_W-1:M_LO] cw;
        logic [REG_W-1:0]   dst;
    } exmem_t;

    // MEM/WB keeps only the WB group plus the destination
    typedef struct packed {
        logic [WB_HI:WB_LO] cw;
        logic [REG_W-1:0]   dst;
    } memwb_t;

    // Pick the youngest in-flight writer of src; register 0 never forwards.
    function automatic fwd_sel_e fwd_select(
        input logic             mem_rw,
        input logic [REG_W-1:0] mem_dst,
        input logic             wb_rw,
        input logic [REG_W-1:0] wb_dst,
        input logic [REG_W-1:0] src
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (mem_rw && (mem_dst != '0) && (mem_dst == src)) begin
            sel = FWD_EXMEM;
        end else if (wb_rw && (wb_dst != '0) && (wb_dst == src)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX-stage forwarding compare: selects each ALU operand source from the
// EX/MEM and MEM/WB writers, EX/MEM having priority.
module fwd_unit
    import mips_ctrl_pkg::*;
(
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             wb_regwrite,
    input  logic [REG_W-1:0] wb_dst,
    input  logic [REG_W-1:0] src_a,
    input  logic [REG_W-1:0] src_b,
    output logic [1:0]       sel_a,
    output logic [1:0]       sel_b
);

    // Same compare applied independently to both operand specifiers
    always_comb begin
        sel_a = fwd_select(mem_regwrite, mem_dst, wb_regwrite, wb_dst, src_a);
        sel_b = fwd_select(mem_regwrite, mem_dst, wb_regwrite, wb_dst, src_b);
    end

endmodule

// File: rtl/ctrl_pipe_carrier.sv
// Carries the decoded control word from ID through ID/EX, EX/MEM and MEM/WB,
// unpacks each stage's fields and produces load-use stall, branch flush and
// EX-stage forwarding selects for the 5-stage MIPS pipeline.
module ctrl_pipe_carrier
    import mips_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CW_W-1:0]  ctrl_id,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             mem_zero,
    output logic             ex_regdst,
    output logic             ex_alusrc,
    output logic             ex_rtype,
    output logic             ex_beq,
    output logic [REG_W-1:0] ex_dst_reg,
    output logic             mem_branch,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic [REG_W-1:0] mem_dst_reg,
    output logic             wb_memtoreg,
    output logic             wb_regwrite,
    output logic [REG_W-1:0] wb_dst_reg,
    output logic             stall,
    output logic             pcsrc,
    output logic             flush_ifid,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    idex_t  idex;
    exmem_t exmem;
    memwb_t memwb;

    logic ex_memread;
    logic mem_regwrite;

    // Stage field unpack and EX destination mux
    always_comb begin
        ex_regdst    = idex.cw[CW_REGDST];
        ex_alusrc    = idex.cw[CW_ALUSRC];
        ex_rtype     = idex.cw[CW_RTYPE];
        ex_beq       = idex.cw[CW_BEQ];
        ex_memread   = idex.cw[CW_MEMREAD];
        ex_dst_reg   = idex.cw[CW_REGDST] ? idex.rd : idex.rt;

        mem_branch   = exmem.cw[CW_BRANCH];
        mem_memread  = exmem.cw[CW_MEMREAD];
        mem_memwrite = exmem.cw[CW_MEMWRITE];
        mem_regwrite = exmem.cw[CW_REGWRITE];
        mem_dst_reg  = exmem.dst;

        wb_memtoreg  = memwb.cw[CW_MEMTOREG];
        wb_regwrite  = memwb.cw[CW_REGWRITE];
        wb_dst_reg   = memwb.dst;
    end

    // Branch resolution in MEM and load-use detection; a taken branch
    // squashes the load's consumer anyway, so it suppresses the stall.
    always_comb begin
        pcsrc      = mem_branch & mem_zero;
        flush_ifid = pcsrc;
        stall      = ex_memread & ~pcsrc & (idex.rt != '0) &
                     ((idex.rt == id_rs) | (idex.rt == id_rt));
    end

    // ID/EX: bubble on flush or stall, otherwise capture the ID instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex <= '0;
        end else if (pcsrc || stall) begin
            idex <= '0;
        end else begin
            idex.cw <= ctrl_id;
            idex.rs <= id_rs;
            idex.rt <= id_rt;
            idex.rd <= id_rd;
        end
    end

    // EX/MEM: bubble on flush, otherwise WB/M groups and resolved destination
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem <= '0;
        end else if (pcsrc) begin
            exmem <= '0;
        end else begin
            exmem.cw  <= idex.cw[CW_W-1:M_LO];
            exmem.dst <= ex_dst_reg;
        end
    end

    // MEM/WB: always advances so the branch itself completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memwb <= '0;
        end else begin
            memwb.cw  <= exmem.cw[WB_HI:WB_LO];
            memwb.dst <= exmem.dst;
        end
    end

    fwd_unit u_fwd (
        .mem_regwrite (mem_regwrite),
        .mem_dst      (exmem.dst),
        .wb_regwrite  (wb_regwrite),
        .wb_dst       (memwb.dst),
        .src_a        (idex.rs),
        .src_b        (idex.rt),
        .sel_a        (fwd_a),
        .sel_b        (fwd_b)
    );

endmodule

// File: tb/tb_ctrl_pipe_carrier.sv
// Directed self-checking bench for ctrl_pipe_carrier.
module tb_ctrl_pipe_carrier;

    logic       clk;
    logic       rst_n;
    logic [8:0] ctrl_id;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       mem_zero;
    logic       ex_regdst, ex_alusrc, ex_rtype, ex_beq;
    logic [4:0] ex_dst_reg;
    logic       mem_branch, mem_memread, mem_memwrite;
    logic [4:0] mem_dst_reg;
    logic       wb_memtoreg, wb_regwrite;
    logic [4:0] wb_dst_reg;
    logic       stall, pcsrc, flush_ifid;
    logic [1:0] fwd_a, fwd_b;

    int checks = 0;
    int errors = 0;

    localparam logic [8:0] CW_R   = 9'h08A; // regwrite, regdst, rtype
    localparam logic [8:0] CW_LW  = 9'h1A4; // memtoreg, regwrite, memread, alusrc
    localparam logic [8:0] CW_BEQ = 9'h041; // branch, beq

    ctrl_pipe_carrier dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl_id      (ctrl_id),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .mem_zero     (mem_zero),
        .ex_regdst    (ex_regdst),
        .ex_alusrc    (ex_alusrc),
        .ex_rtype     (ex_rtype),
        .ex_beq       (ex_beq),
        .ex_dst_reg   (ex_dst_reg),
        .mem_branch   (mem_branch),
        .mem_memread  (mem_memread),
        .mem_memwrite (mem_memwrite),
        .mem_dst_reg  (mem_dst_reg),
        .wb_memtoreg  (wb_memtoreg),
        .wb_regwrite  (wb_regwrite),
        .wb_dst_reg   (wb_dst_reg),
        .stall        (stall),
        .pcsrc        (pcsrc),
        .flush_ifid   (flush_ifid),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [30:0] all_outs();
        return {ex_regdst, ex_alusrc, ex_rtype, ex_beq, ex_dst_reg,
                mem_branch, mem_memread, mem_memwrite, mem_dst_reg,
                wb_memtoreg, wb_regwrite, wb_dst_reg,
                stall, pcsrc, flush_ifid, fwd_a, fwd_b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [8:0] cw, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd);
        ctrl_id = cw;
        id_rs   = rs;
        id_rt   = rt;
        id_rd   = rd;
        #1;
    endtask

    task automatic do_reset();
        set_id('0, '0, '0, '0);
        mem_zero = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n    = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        mem_zero = 1'b0;
        set_id(9'h1FF, 5'd1, 5'd2, 5'd7);
        repeat (3) step();
        checks++; if (all_outs() !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs()); end
        rst_n = 1'b1;
        #1;
        checks++; if (all_outs() !== '0) begin errors++; $display("FAIL reset_release_no_capture: got %h expected 0", all_outs()); end
        step();
        checks++; if ({ex_regdst, ex_alusrc, ex_rtype, ex_beq} !== 4'hF) begin errors++; $display("FAIL reset_first_ex: got %b expected 1111", {ex_regdst, ex_alusrc, ex_rtype, ex_beq}); end
        checks++; if (ex_dst_reg !== 5'd7) begin errors++; $display("FAIL reset_first_dst: got %0d expected 7", ex_dst_reg); end
        // memread set in the captured word and rt=2 matches id_rt
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_first_stall: got %b expected 1", stall); end
    endtask

    task automatic test_propagation();
        do_reset();
        set_id(CW_R, 5'd1, 5'd2, 5'd5);
        step();
        set_id('0, '0, '0, '0);
        checks++; if (ex_dst_reg !== 5'd5) begin errors++; $display("FAIL prop_ex_dst: got %0d expected 5", ex_dst_reg); end
        checks++; if ({ex_regdst, ex_alusrc, ex_rtype, ex_beq} !== 4'b1010) begin errors++; $display("FAIL prop_ex_fields: got %b expected 1010", {ex_regdst, ex_alusrc, ex_rtype, ex_beq}); end
        step();
        checks++; if (mem_dst_reg !== 5'd5) begin errors++; $display("FAIL prop_mem_dst: got %0d expected 5", mem_dst_reg); end
        checks++; if ({mem_branch, mem_memread, mem_memwrite} !== 3'b000) begin errors++; $display("FAIL prop_mem_fields: got %b expected 000", {mem_branch, mem_memread, mem_memwrite}); end
        step();
        checks++; if ({wb_memtoreg, wb_regwrite, wb_dst_reg} !== {2'b01, 5'd5}) begin errors++; $display("FAIL prop_wb: got %b expected 0100101", {wb_memtoreg, wb_regwrite, wb_dst_reg}); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(CW_LW, 5'd2, 5'd8, 5'd0);
        step();
        set_id(CW_R, 5'd8, 5'd9, 5'd10);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_on: got %b expected 1", stall); end
        checks++; if (ex_dst_reg !== 5'd8) begin errors++; $display("FAIL lu_lw_dst: got %0d expected 8", ex_dst_reg); end
        step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_off: got %b expected 0", stall); end
        checks++; if ({ex_regdst, ex_alusrc, ex_rtype, ex_beq, ex_dst_reg} !== '0) begin errors++; $display("FAIL lu_bubble: got %b expected 0", {ex_regdst, ex_alusrc, ex_rtype, ex_beq, ex_dst_reg}); end
        checks++; if ({mem_memread, mem_dst_reg} !== {1'b1, 5'd8}) begin errors++; $display("FAIL lu_mem_lw: got %b expected 101000", {mem_memread, mem_dst_reg}); end
        step();
        set_id('0, '0, '0, '0);
        checks++; if (ex_dst_reg !== 5'd10) begin errors++; $display("FAIL lu_dep_in_ex: got %0d expected 10", ex_dst_reg); end
        checks++; if ({fwd_a, fwd_b} !== 4'b0100) begin errors++; $display("FAIL lu_fwd: got %b expected 0100", {fwd_a, fwd_b}); end
        checks++; if ({wb_memtoreg, wb_regwrite, wb_dst_reg} !== {2'b11, 5'd8}) begin errors++; $display("FAIL lu_wb: got %b expected 1101000", {wb_memtoreg, wb_regwrite, wb_dst_reg}); end
    endtask

    task automatic test_forwarding();
        // back-to-back producer rd=3, consumer rs=rt=3
        do_reset();
        set_id(CW_R, 5'd1, 5'd2, 5'd3);
        step();
        set_id(CW_R, 5'd3, 5'd3, 5'd4);
        step();
        set_id('0, '0, '0, '0);
        checks++; if ({fwd_a, fwd_b} !== 4'b1010) begin errors++; $display("FAIL fwd_exmem: got %b expected 1010", {fwd_a, fwd_b}); end
        // one independent instruction between
        do_reset();
        set_id(CW_R, 5'd1, 5'd2, 5'd3);
        step();
        set_id(CW_R, 5'd1, 5'd2, 5'd6);
        step();
        set_id(CW_R, 5'd3, 5'd3, 5'd4);
        step();
        set_id('0, '0, '0, '0);
        checks++; if ({fwd_a, fwd_b} !== 4'b0101) begin errors++; $display("FAIL fwd_memwb: got %b expected 0101", {fwd_a, fwd_b}); end
        // both stages write r3: EX/MEM wins
        do_reset();
        set_id(CW_R, 5'd1, 5'd2, 5'd3);
        step();
        set_id(CW_R, 5'd1, 5'd2, 5'd3);
        step();
        set_id(CW_R, 5'd3, 5'd2, 5'd4);
        step();
        set_id('0, '0, '0, '0);
        checks++; if ({fwd_a, fwd_b} !== 4'b1000) begin errors++; $display("FAIL fwd_priority: got %b expected 1000", {fwd_a, fwd_b}); end
        // destination r0 never forwards
        do_reset();
        set_id(CW_R, 5'd1, 5'd2, 5'd0);
        step();
        set_id(CW_R, 5'd0, 5'd0, 5'd4);
        step();
        set_id('0, '0, '0, '0);
        checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL fwd_r0: got %b expected 0000", {fwd_a, fwd_b}); end
    endtask

    task automatic test_branch(input logic zero);
        do_reset();
        set_id(CW_BEQ, 5'd1, 5'd2, 5'd0);
        step();
        set_id(CW_R, 5'd4, 5'd5, 5'd6);
        step();
        set_id(CW_R, 5'd7, 5'd7, 5'd9);
        mem_zero = zero;
        #1;
        checks++; if ({pcsrc, flush_ifid} !== {zero, zero}) begin errors++; $display("FAIL br_pcsrc_z%0d: got %b expected %b", zero, {pcsrc, flush_ifid}, {zero, zero}); end
        step();
        if (zero) begin
            checks++; if ({ex_dst_reg, mem_branch, mem_dst_reg} !== '0) begin errors++; $display("FAIL br_flushed: got %b expected 0", {ex_dst_reg, mem_branch, mem_dst_reg}); end
        end else begin
            checks++; if ({ex_dst_reg, mem_dst_reg} !== {5'd9, 5'd6}) begin errors++; $display("FAIL br_not_taken: got %b expected 0100100110", {ex_dst_reg, mem_dst_reg}); end
        end
        checks++; if ({wb_regwrite, wb_dst_reg} !== {1'b0, 5'd2}) begin errors++; $display("FAIL br_wb_z%0d: got %b expected 000010", zero, {wb_regwrite, wb_dst_reg}); end
        checks++; if (pcsrc !== 1'b0) begin errors++; $display("FAIL br_pcsrc_after_z%0d: got %b expected 0", zero, pcsrc); end
    endtask

    task automatic test_flush_beats_stall();
        do_reset();
        set_id(CW_BEQ, 5'd1, 5'd2, 5'd0);
        step();
        set_id(CW_LW, 5'd1, 5'd8, 5'd0);
        step();
        set_id(CW_R, 5'd8, 5'd3, 5'd10);
        mem_zero = 1'b1;
        #1;
        checks++; if ({stall, pcsrc} !== 2'b01) begin errors++; $display("FAIL fbs_priority: got %b expected 01", {stall, pcsrc}); end
        step();
        checks++; if ({ex_dst_reg, mem_memread, mem_dst_reg} !== '0) begin errors++; $display("FAIL fbs_bubbles: got %b expected 0", {ex_dst_reg, mem_memread, mem_dst_reg}); end
        checks++; if (wb_dst_reg !== 5'd2) begin errors++; $display("FAIL fbs_wb: got %0d expected 2", wb_dst_reg); end
        step();
        step();
        checks++; if ({ex_dst_reg, mem_dst_reg} !== {5'd10, 5'd10}) begin errors++; $display("FAIL fbs_refill: got %b expected 0101001010", {ex_dst_reg, mem_dst_reg}); end
        // asynchronous reset mid-cycle
        rst_n = 1'b0;
        #1;
        checks++; if (all_outs() !== '0) begin errors++; $display("FAIL mid_reset: got %h expected 0", all_outs()); end
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        mem_zero = 1'b0;
        ctrl_id  = '0;
        id_rs    = '0;
        id_rt    = '0;
        id_rd    = '0;
        test_reset();
        test_propagation();
        test_load_use();
        test_forwarding();
        test_branch(1'b1);
        test_branch(1'b0);
        test_flush_beats_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
